store_queue_param: RTL and testbench

Parametrised store queue for the out-of-order memory pipeline. It is the next generation of the store queue, generalised in depth and data width. It adds three things the store queue lacks:
- a post-commit write-buffer region, split from the speculative region by a separate commit pointer;
- byte-granular store-to-load forwarding that merges bytes from several older stores;
- a single-cycle squash of all uncommitted stores.

It sits between dispatch/RS (allocate, resolve), the ROB (commit, squash), the load buffer (forward query) and the D-cache (drain).

---
 rtl/store_queue_param_if.sv | 67 ++++++
 rtl/store_queue_param.sv | 153 +++++++++++++++
 tb/tb_store_queue_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_param_if.sv
// Bus bundle for store_queue_param: dispatch, resolve, ROB, drain and load-forwarding channels.
// The slave modport is the queue itself; the master modport is its surrounding pipeline.
interface store_queue_param_if #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32,
   parameter int ROB_W = 5,
   parameter int IDX_W = $clog2(DEPTH)
);
   logic                  alloc_valid;
   logic [ROB_W-1:0]      alloc_rob_idx;
   logic                  alloc_ready;
   logic [IDX_W:0]        alloc_idx;

   logic                  res_valid;
   logic [IDX_W-1:0]      res_idx;
   logic [XLEN-1:0]       res_addr;
   logic [XLEN-1:0]       res_data;
   logic [1:0]            res_size;

   logic                  commit_valid;
   logic                  commit_ready;
   logic                  squash_valid;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [XLEN-1:0]       mem_req_addr;
   logic [XLEN-1:0]       mem_req_data;
   logic [XLEN/8-1:0]     mem_req_be;

   logic                  ld_valid;
   logic [IDX_W:0]        ld_age;
   logic [XLEN-1:0]       ld_addr;
   logic [1:0]            ld_size;
   logic                  ld_fwd_hit;
   logic [XLEN-1:0]       ld_fwd_data;
   logic [XLEN/8-1:0]     ld_fwd_mask;
   logic                  ld_stall;

   logic [IDX_W:0]        count;
   logic                  empty;

   modport slave (
      input  alloc_valid, alloc_rob_idx,
      output alloc_ready, alloc_idx,
      input  res_valid, res_idx, res_addr, res_data, res_size,
      input  commit_valid, squash_valid,
      output commit_ready,
      output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
      input  mem_req_ready,
      input  ld_valid, ld_age, ld_addr, ld_size,
      output ld_fwd_hit, ld_fwd_data, ld_fwd_mask, ld_stall,
      output count, empty
   );

   modport master (
      output alloc_valid, alloc_rob_idx,
      input  alloc_ready, alloc_idx,
      output res_valid, res_idx, res_addr, res_data, res_size,
      output commit_valid, squash_valid,
      input  commit_ready,
      input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
      output mem_req_ready,
      output ld_valid, ld_age, ld_addr, ld_size,
      input  ld_fwd_hit, ld_fwd_data, ld_fwd_mask, ld_stall,
      input  count, empty
   );
endinterface

// File: rtl/store_queue_param.sv
// Parametrised store queue: speculative region [cmt,tail), post-commit write buffer [head,cmt),
// byte-granular store-to-load forwarding and single-cycle squash of uncommitted stores.
module store_queue_param #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32,
   parameter int ROB_W = 5,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   store_queue_param_if.slave  bus
);
   localparam int BW    = XLEN / 8;
   localparam int OFF_W = $clog2(BW);
   localparam int PTR_W = IDX_W + 1;

   // Byte enables for a naturally aligned access of the given size, before lane shifting.
   function automatic logic [BW-1:0] size_mask(input logic [1:0] size);
      logic [BW-1:0] m;
      m = '0;
      for (int b = 0; b < BW; b++)
         if (b < (1 << size)) m[b] = 1'b1;
      return m;
   endfunction

   function automatic logic [BW-1:0] lane_mask(input logic [OFF_W-1:0] off, input logic [1:0] size);
      return size_mask(size) << off;
   endfunction

   function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] data,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [1:0] size);
      logic [BW-1:0]   m;
      logic [XLEN-1:0] bits;
      m = size_mask(size);
      bits = '0;
      for (int b = 0; b < BW; b++)
         bits[8*b +: 8] = {8{m[b]}};
      return (data & bits) << {off, 3'b000};
   endfunction

   logic [PTR_W-1:0] head_q, cmt_q, tail_q;
   logic [DEPTH-1:0] resolved_q;
   logic [XLEN-1:0]  addr_q [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [1:0]       size_q [DEPTH];
   logic [ROB_W-1:0] rob_q  [DEPTH];

   logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx, res_rel;
   logic [PTR_W-1:0] occ_cnt, spec_cnt, cmt_nxt;
   logic             full, alloc_fire, commit_fire, drain_fire, res_fire;

   assign head_idx = head_q[IDX_W-1:0];
   assign cmt_idx  = cmt_q[IDX_W-1:0];
   assign tail_idx = tail_q[IDX_W-1:0];
   assign occ_cnt  = tail_q - head_q;
   assign spec_cnt = tail_q - cmt_q;
   assign full     = (occ_cnt == PTR_W'(DEPTH));

   assign bus.count         = occ_cnt;
   assign bus.empty         = (occ_cnt == '0);
   assign bus.alloc_ready   = !full;
   assign bus.alloc_idx     = tail_q;
   assign bus.commit_ready  = (spec_cnt != '0) && resolved_q[cmt_idx];
   assign bus.mem_req_valid = (head_q != cmt_q);

   assign alloc_fire  = bus.alloc_valid && !full && !bus.squash_valid;
   assign commit_fire = bus.commit_valid && bus.commit_ready;
   assign drain_fire  = bus.mem_req_valid && bus.mem_req_ready;
   assign cmt_nxt     = cmt_q + {{IDX_W{1'b0}}, commit_fire};

   // A resolve must land in the speculative region; under squash every such entry dies.
   assign res_rel  = bus.res_idx - cmt_idx;
   assign res_fire = bus.res_valid && !bus.squash_valid &&
                     ({1'b0, res_rel} < spec_cnt) && !resolved_q[bus.res_idx];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         cmt_q      <= '0;
         tail_q     <= '0;
         resolved_q <= '0;
      end else begin
         cmt_q <= cmt_nxt;
         if (drain_fire)
            head_q <= head_q + 1'b1;
         if (bus.squash_valid)
            tail_q <= cmt_nxt;
         else if (alloc_fire)
            tail_q <= tail_q + 1'b1;
         if (alloc_fire)
            resolved_q[tail_idx] <= 1'b0;
         if (res_fire)
            resolved_q[bus.res_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (alloc_fire)
         rob_q[tail_idx] <= bus.alloc_rob_idx;
      if (res_fire) begin
         addr_q[bus.res_idx] <= bus.res_addr;
         data_q[bus.res_idx] <= bus.res_data;
         size_q[bus.res_idx] <= bus.res_size;
      end
   end

   assign bus.mem_req_addr = {addr_q[head_idx][XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign bus.mem_req_data = lane_data(data_q[head_idx], addr_q[head_idx][OFF_W-1:0], size_q[head_idx]);
   assign bus.mem_req_be   = lane_mask(addr_q[head_idx][OFF_W-1:0], size_q[head_idx]);

   logic [BW-1:0]    ld_need, fwd_mask, st_be;
   logic [XLEN-1:0]  fwd_data, st_data;
   logic [PTR_W-1:0] win;
   logic [IDX_W-1:0] k;
   logic             unres;

   // Oldest-to-youngest scan, so a younger matching store overwrites an older one per lane.
   always_comb begin
      ld_need  = lane_mask(bus.ld_addr[OFF_W-1:0], bus.ld_size);
      fwd_mask = '0;
      fwd_data = '0;
      st_be    = '0;
      st_data  = '0;
      k        = '0;
      unres    = 1'b0;
      win      = bus.ld_age - head_q;
      if (win > occ_cnt)
         win = '0;
      for (int i = 0; i < DEPTH; i++) begin
         k = head_idx + IDX_W'(i);
         if (PTR_W'(i) < win) begin
            if (!resolved_q[k]) begin
               unres = 1'b1;
            end else if (addr_q[k][XLEN-1:OFF_W] == bus.ld_addr[XLEN-1:OFF_W]) begin
               st_be   = lane_mask(addr_q[k][OFF_W-1:0], size_q[k]);
               st_data = lane_data(data_q[k], addr_q[k][OFF_W-1:0], size_q[k]);
               for (int b = 0; b < BW; b++) begin
                  if (ld_need[b] && st_be[b]) begin
                     fwd_mask[b]        = 1'b1;
                     fwd_data[8*b +: 8] = st_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign bus.ld_fwd_hit  = bus.ld_valid && !unres && (fwd_mask == ld_need);
   assign bus.ld_stall    = bus.ld_valid && (unres || ((fwd_mask != '0) && (fwd_mask != ld_need)));
   assign bus.ld_fwd_mask = bus.ld_valid ? fwd_mask : '0;
   assign bus.ld_fwd_data = bus.ld_valid ? fwd_data : '0;
endmodule

// File: tb/tb_store_queue_param.sv
// Directed bench for store_queue_param (DEPTH=8, XLEN=32): allocation/wrap, drain handshake,
// byte-merge forwarding, age-ordered forwarding, commit+squash and asynchronous reset.
module tb_store_queue_param;
   logic clock;
   logic reset;
   int   passed;
   int   total;

   store_queue_param_if #(.DEPTH(8), .XLEN(32), .ROB_W(5)) sq ();

   store_queue_param #(.DEPTH(8), .XLEN(32), .ROB_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (sq.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      step();
   endtask

   task automatic alloc_n(input int n);
      sq.alloc_valid = 1'b1;
      repeat (n) step();
      sq.alloc_valid = 1'b0;
   endtask

   task automatic resolve(input logic [2:0] idx, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size);
      sq.res_valid = 1'b1;
      sq.res_idx   = idx;
      sq.res_addr  = addr;
      sq.res_data  = data;
      sq.res_size  = size;
      step();
      sq.res_valid = 1'b0;
   endtask

   task automatic load(input logic [3:0] age, input logic [31:0] addr, input logic [1:0] size);
      sq.ld_valid = 1'b1;
      sq.ld_age   = age;
      sq.ld_addr  = addr;
      sq.ld_size  = size;
      #1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b0;
      sq.alloc_valid = 0; sq.alloc_rob_idx = 0;
      sq.res_valid = 0; sq.res_idx = 0; sq.res_addr = 0; sq.res_data = 0; sq.res_size = 0;
      sq.commit_valid = 0; sq.squash_valid = 0; sq.mem_req_ready = 0;
      sq.ld_valid = 0; sq.ld_age = 0; sq.ld_addr = 0; sq.ld_size = 0;

      #2;
      chk("rst_alloc_ready", sq.alloc_ready, 1);
      chk("rst_alloc_idx", sq.alloc_idx, 0);
      chk("rst_commit_ready", sq.commit_ready, 0);
      chk("rst_mem_req_valid", sq.mem_req_valid, 0);
      chk("rst_count", sq.count, 0);
      chk("rst_empty", sq.empty, 1);
      chk("rst_fwd_hit", sq.ld_fwd_hit, 0);
      chk("rst_stall", sq.ld_stall, 0);
      #1 reset = 1'b1;
      step();

      // fill to full, then wrap
      for (int i = 0; i < 8; i++) begin
         chk("alloc_idx_seq", sq.alloc_idx, i);
         sq.alloc_valid   = 1'b1;
         sq.alloc_rob_idx = 5'(i);
         step();
      end
      chk("full_alloc_idx", sq.alloc_idx, 8);
      chk("full_count", sq.count, 8);
      chk("full_alloc_ready", sq.alloc_ready, 0);
      chk("full_empty", sq.empty, 0);
      chk("unresolved_commit_ready", sq.commit_ready, 0);
      step();
      sq.alloc_valid = 1'b0;
      chk("ninth_alloc_idx", sq.alloc_idx, 8);
      chk("ninth_count", sq.count, 8);

      // resolve, commit, drain with back-pressure
      resolve(0, 32'h100, 32'hAABBCCDD, 2);
      chk("resolved_commit_ready", sq.commit_ready, 1);
      chk("no_req_before_commit", sq.mem_req_valid, 0);
      sq.commit_valid = 1'b1;
      step();
      sq.commit_valid = 1'b0;
      chk("drain_valid", sq.mem_req_valid, 1);
      chk("drain_addr", sq.mem_req_addr, 32'h100);
      chk("drain_data", sq.mem_req_data, 32'hAABBCCDD);
      chk("drain_be", sq.mem_req_be, 4'hF);
      chk("next_commit_ready", sq.commit_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_valid", sq.mem_req_valid, 1);
         chk("hold_addr", sq.mem_req_addr, 32'h100);
         chk("hold_data", sq.mem_req_data, 32'hAABBCCDD);
         chk("hold_count", sq.count, 8);
      end
      sq.mem_req_ready = 1'b1;
      sq.alloc_valid   = 1'b1;
      step();
      sq.mem_req_ready = 1'b0;
      sq.alloc_valid   = 1'b0;
      chk("post_drain_count", sq.count, 7);
      chk("post_drain_valid", sq.mem_req_valid, 0);
      chk("full_alloc_dropped", sq.alloc_idx, 8);
      chk("post_drain_ready", sq.alloc_ready, 1);
      alloc_n(1);
      chk("wrap_alloc_idx", sq.alloc_idx, 9);
      chk("wrap_count", sq.count, 8);
      chk("wrap_alloc_ready", sq.alloc_ready, 0);

      // byte-merge forwarding
      apply_reset();
      chk("reset2_count", sq.count, 0);
      alloc_n(2);
      resolve(0, 32'h203, 32'h11, 0);
      resolve(1, 32'h200, 32'h2233, 1);
      load(2, 32'h200, 2);
      chk("partial_hit", sq.ld_fwd_hit, 0);
      chk("partial_stall", sq.ld_stall, 1);
      chk("partial_mask", sq.ld_fwd_mask, 4'b1011);
      load(2, 32'h200, 1);
      chk("half_hit", sq.ld_fwd_hit, 1);
      chk("half_stall", sq.ld_stall, 0);
      chk("half_mask", sq.ld_fwd_mask, 4'b0011);
      chk("half_data", sq.ld_fwd_data[15:0], 16'h2233);
      load(2, 32'h203, 0);
      chk("byte_hit", sq.ld_fwd_hit, 1);
      chk("byte_data", sq.ld_fwd_data[31:24], 8'h11);
      load(1, 32'h200, 1);
      chk("young_store_excluded_hit", sq.ld_fwd_hit, 0);
      chk("young_store_excluded_stall", sq.ld_stall, 0);
      chk("young_store_excluded_mask", sq.ld_fwd_mask, 0);
      sq.ld_valid = 1'b0;
      #1;
      chk("idle_hit", sq.ld_fwd_hit, 0);
      chk("idle_mask", sq.ld_fwd_mask, 0);
      chk("idle_data", sq.ld_fwd_data, 0);

      // youngest older store wins
      apply_reset();
      alloc_n(3);
      resolve(0, 32'h300, 32'h1, 2);
      resolve(1, 32'h300, 32'h2, 2);
      load(1, 32'h300, 2);
      chk("age1_hit", sq.ld_fwd_hit, 1);
      chk("age1_data", sq.ld_fwd_data, 32'h1);
      load(2, 32'h300, 2);
      chk("age2_hit", sq.ld_fwd_hit, 1);
      chk("age2_data", sq.ld_fwd_data, 32'h2);
      load(3, 32'h300, 2);
      chk("unres_stall", sq.ld_stall, 1);
      chk("unres_hit", sq.ld_fwd_hit, 0);
      load(2, 32'h400, 2);
      chk("miss_hit", sq.ld_fwd_hit, 0);
      chk("miss_stall", sq.ld_stall, 0);
      sq.ld_valid = 1'b0;

      // commit + squash in the same cycle
      apply_reset();
      alloc_n(3);
      resolve(0, 32'h500, 32'hA, 2);
      resolve(1, 32'h504, 32'hB, 2);
      resolve(2, 32'h508, 32'hC, 2);
      sq.commit_valid = 1'b1;
      step();
      sq.squash_valid = 1'b1;
      sq.alloc_valid  = 1'b1;
      step();
      sq.commit_valid = 1'b0;
      sq.squash_valid = 1'b0;
      sq.alloc_valid  = 1'b0;
      chk("squash_tail", sq.alloc_idx, 2);
      chk("squash_count", sq.count, 2);
      chk("squash_commit_ready", sq.commit_ready, 0);
      chk("squash_mem_valid", sq.mem_req_valid, 1);
      chk("squash_head_addr", sq.mem_req_addr, 32'h500);
      alloc_n(1);
      chk("realloc_idx", sq.alloc_idx, 3);
      chk("realloc_unresolved", sq.commit_ready, 0);

      // asynchronous reset during a drain
      sq.mem_req_ready = 1'b1;
      step();
      chk("mid_drain_valid", sq.mem_req_valid, 1);
      chk("mid_drain_addr", sq.mem_req_addr, 32'h504);
      #2 reset = 1'b0;
      #1;
      chk("async_mem_valid", sq.mem_req_valid, 0);
      chk("async_count", sq.count, 0);
      chk("async_empty", sq.empty, 1);
      chk("async_alloc_idx", sq.alloc_idx, 0);
      chk("async_commit_ready", sq.commit_ready, 0);
      sq.mem_req_ready = 1'b0;
      reset = 1'b1;
      step();
      alloc_n(1);
      load(1, 32'h500, 2);
      chk("after_reset_unres_stall", sq.ld_stall, 1);
      sq.ld_valid = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
